// File: rtl/main_memory_pipelined_if.sv
// Bus bundle for main_memory_pipelined: instruction read port, Wishbone pipelined data port and ready flag.
// The memory side uses the slave modport; the requester side uses the master modport.
interface main_memory_pipelined_if #(
    parameter int AW         = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic [AW-1:0]         i_inst_addr;
    logic                  i_stb_inst;
    logic                  o_inst_stall;
    logic                  o_ack_inst;
    logic [DATA_WIDTH-1:0] o_inst_out;

    logic                  i_wb_cyc;
    logic                  i_wb_stb;
    logic                  i_wb_we;
    logic [AW-1:0]         i_wb_addr;
    logic [DATA_WIDTH-1:0] i_wb_data;
    logic [SW-1:0]         i_wb_sel;
    logic                  o_wb_stall;
    logic                  o_wb_ack;
    logic                  o_wb_err;
    logic [DATA_WIDTH-1:0] o_wb_data;

    logic                  o_ready;

    modport slave (
        input  i_inst_addr, i_stb_inst,
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_inst_stall, o_ack_inst, o_inst_out,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
        output o_ready
    );

    modport master (
        output i_inst_addr, i_stb_inst,
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_inst_stall, o_ack_inst, o_inst_out,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
        input  o_ready
    );
endinterface

// File: rtl/main_memory_pipelined.sv
// Dual-port byte-addressed memory: instruction read port plus Wishbone pipelined data port; MAIN_MEMORY_CLEAR_EN zero-fills after reset.
// Latency: every accepted request answers exactly READ_LATENCY cycles later, in order, per port.
// Backpressure: both ports stall only until READY; dropping i_wb_cyc discards in-flight data responses.
module main_memory_pipelined #(
    parameter int MEMORY_DEPTH = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    main_memory_pipelined_if.slave bus
);
    localparam int AW    = $clog2(MEMORY_DEPTH);
    localparam int SW    = DATA_WIDTH / 8;
    localparam int OB    = $clog2(SW);
    localparam int WORDS = MEMORY_DEPTH / SW;
    localparam int WW    = AW - OB;
    localparam int LAST  = READ_LATENCY - 1;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t state_q;
    state_t state_d;
    logic   ready;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic          inst_acc;
    logic          wb_acc;
    logic          wb_misal;
    logic          wb_wr_en;
    logic [WW-1:0] inst_idx;
    logic [WW-1:0] wb_idx;
    logic          inst_lsb_unused;

    assign inst_idx        = bus.i_inst_addr[AW-1:OB];
    assign wb_idx          = bus.i_wb_addr[AW-1:OB];
    assign inst_lsb_unused = ^bus.i_inst_addr[OB-1:0];

    assign inst_acc = bus.i_stb_inst && ready;
    assign wb_acc   = bus.i_wb_cyc && bus.i_wb_stb && ready;
    assign wb_misal = (bus.i_wb_addr[OB-1:0] != '0);
    assign wb_wr_en = wb_acc && bus.i_wb_we && !wb_misal;

`ifdef MAIN_MEMORY_CLEAR_EN
    logic [WW-1:0] clr_cnt;
    logic          clr_we;

    assign clr_we = (state_q == CLEAR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clr_cnt <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR: begin
`ifdef MAIN_MEMORY_CLEAR_EN
                // Leave CLEAR on the same edge that zeroes the last word.
                if (clr_cnt == WW'(WORDS - 1)) begin
                    state_d = READY;
                end
`else
                state_d = READY;
`endif
            end
            default: state_d = READY;
        endcase
    end

    always_comb begin
        ready = (state_q == READY);
    end

    // Storage has no reset; the clear sequence and the data port never overlap because writes need READY.
    always_ff @(posedge i_clk) begin
`ifdef MAIN_MEMORY_CLEAR_EN
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end
`endif
        if (wb_wr_en) begin
            for (int k = 0; k < SW; k++) begin
                if (bus.i_wb_sel[k]) begin
                    mem[wb_idx][8*k +: 8] <= bus.i_wb_data[8*k +: 8];
                end
            end
        end
    end

    logic [READ_LATENCY-1:0] inst_vld_q;
    logic [DATA_WIDTH-1:0]   inst_dat_q [READ_LATENCY];

    // Payload stages load only behind a valid, so the last stage holds its value between responses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inst_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                inst_dat_q[i] <= '0;
            end
        end else begin
            inst_vld_q[0] <= inst_acc;
            if (inst_acc) begin
                inst_dat_q[0] <= mem[inst_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                inst_vld_q[i] <= inst_vld_q[i-1];
                if (inst_vld_q[i-1]) begin
                    inst_dat_q[i] <= inst_dat_q[i-1];
                end
            end
        end
    end

    logic [READ_LATENCY-1:0] wb_vld_q;
    logic [READ_LATENCY-1:0] wb_err_q;
    logic [DATA_WIDTH-1:0]   wb_dat_q [READ_LATENCY];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_vld_q <= '0;
            wb_err_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                wb_dat_q[i] <= '0;
            end
        end else begin
            wb_vld_q[0] <= wb_acc;
            if (wb_acc) begin
                wb_err_q[0] <= wb_misal;
                wb_dat_q[0] <= wb_misal ? '0 : mem[wb_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                wb_vld_q[i] <= wb_vld_q[i-1];
                if (wb_vld_q[i-1]) begin
                    wb_err_q[i] <= wb_err_q[i-1];
                    wb_dat_q[i] <= wb_dat_q[i-1];
                end
            end
            if (!bus.i_wb_cyc) begin
                wb_vld_q <= '0;
            end
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_inst_stall = !ready;
    assign bus.o_wb_stall   = !ready;
    assign bus.o_ack_inst   = inst_vld_q[LAST];
    assign bus.o_inst_out   = inst_dat_q[LAST];
    // A response due in a cycle where the master has already dropped cyc is swallowed too.
    assign bus.o_wb_ack     = wb_vld_q[LAST] && !wb_err_q[LAST] && bus.i_wb_cyc;
    assign bus.o_wb_err     = wb_vld_q[LAST] && wb_err_q[LAST] && bus.i_wb_cyc;
    assign bus.o_wb_data    = wb_dat_q[LAST];
endmodule

// File: tb/tb_main_memory_pipelined.sv
// Bench for main_memory_pipelined: directed scenarios plus randomized two-port traffic against a byte-array model.
module tb_main_memory_pipelined;
`ifdef MAIN_MEMORY_CLEAR_EN
    localparam int EXP_READY = 1024;
`else
    localparam int EXP_READY = 1;
`endif

    typedef struct {
        int          cyc;
        bit          err;
        bit          wr;
        logic [63:0] dat;
    } rsp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    int   cyc_n = 0;
    int   total = 0;
    int   bad   = 0;
    int   both_cnt = 0;

    logic [7:0] mm [4096];
    rsp_t obs_wb[$];
    rsp_t obs_inst[$];
    rsp_t obs_w[$];
    rsp_t exp_wb[$];
    rsp_t exp_inst[$];

    main_memory_pipelined_if #(.AW(12), .DATA_WIDTH(32)) bus ();
    main_memory_pipelined_if #(.AW(12), .DATA_WIDTH(64)) wbus ();

    main_memory_pipelined dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
    main_memory_pipelined #(.DATA_WIDTH(64), .READ_LATENCY(4)) dut_w (.i_clk(i_clk), .i_rst(i_rst), .bus(wbus));

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    always @(negedge i_clk) begin
        rsp_t r;
        if (bus.o_wb_ack && bus.o_wb_err) both_cnt++;
        if (wbus.o_wb_ack && wbus.o_wb_err) both_cnt++;
        if (bus.o_wb_ack || bus.o_wb_err) begin
            r.cyc = cyc_n; r.err = bus.o_wb_err; r.wr = 1'b0; r.dat = 64'(bus.o_wb_data);
            obs_wb.push_back(r);
        end
        if (bus.o_ack_inst) begin
            r.cyc = cyc_n; r.err = 1'b0; r.wr = 1'b0; r.dat = 64'(bus.o_inst_out);
            obs_inst.push_back(r);
        end
        if (wbus.o_wb_ack || wbus.o_wb_err) begin
            r.cyc = cyc_n; r.err = wbus.o_wb_err; r.wr = 1'b0; r.dat = wbus.o_wb_data;
            obs_w.push_back(r);
        end
    end

    function automatic logic [31:0] mrd(input logic [11:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = mm[int'({a[11:2], 2'b00}) + b];
        return r;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wb_idle(input bit cyc);
        bus.i_wb_cyc = cyc; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    endtask

    // Drives one data request for the current cycle and applies its effect to the model.
    task automatic wb_req(input bit we, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = we;
        bus.i_wb_addr = a; bus.i_wb_data = d; bus.i_wb_sel = s;
        if (we && a[1:0] == 2'b00)
            for (int b = 0; b < 4; b++) if (s[b]) mm[int'(a) + b] = d[8*b +: 8];
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 3000) begin step(); n++; end
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if ({bus.o_ready, bus.o_inst_stall, bus.o_wb_stall, bus.o_ack_inst, bus.o_wb_ack, bus.o_wb_err} !== 6'b011000) begin
            bad++; $display("FAIL reset_flags got=%b want=011000",
                {bus.o_ready, bus.o_inst_stall, bus.o_wb_stall, bus.o_ack_inst, bus.o_wb_ack, bus.o_wb_err});
        end
        total++;
        if (bus.o_inst_out !== 32'h0) begin bad++; $display("FAIL reset_inst_out got=%h want=0", bus.o_inst_out); end
        total++;
        if (bus.o_wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h want=0", bus.o_wb_data); end
    endtask

    task automatic test_ready();
        int n;
        i_rst = 1'b0;
        wait_ready(n);
        total++;
        if (n != EXP_READY) begin bad++; $display("FAIL ready_cycles got=%0d want=%0d", n, EXP_READY); end
        total++;
        if (bus.o_inst_stall !== 1'b0 || bus.o_wb_stall !== 1'b0) begin
            bad++; $display("FAIL ready_stall got=%b%b want=00", bus.o_inst_stall, bus.o_wb_stall);
        end
`ifdef MAIN_MEMORY_CLEAR_EN
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        obs_wb.delete();
        wb_req(1'b0, 12'h7FC, 32'h0, 4'hF); step();
        wb_idle(1'b1); repeat (4) step();
        total++;
        if (obs_wb.size() != 1 || obs_wb[0].dat !== 64'h0) begin
            bad++; $display("FAIL clear_read got=%0d rsp want=1 rsp of 0", obs_wb.size());
        end
`endif
    endtask

    task automatic test_preload();
        obs_wb.delete();
        for (int i = 0; i < 64; i++) begin wb_req(1'b1, 12'(i * 4), $urandom, 4'hF); step(); end
        wb_idle(1'b1); repeat (4) step();
        total++;
        if (obs_wb.size() != 64) begin bad++; $display("FAIL preload_acks got=%0d want=64", obs_wb.size()); end
    endtask

    task automatic test_byte_lanes();
        int k[3];
        obs_wb.delete();
        k[0] = cyc_n; wb_req(1'b1, 12'h010, 32'hDEADBEEF, 4'hF); step();
        k[1] = cyc_n; wb_req(1'b1, 12'h010, 32'h000000AA, 4'h1); step();
        k[2] = cyc_n; wb_req(1'b0, 12'h010, 32'h0, 4'hF); step();
        wb_idle(1'b1); repeat (4) step();
        total++;
        if (obs_wb.size() != 3) begin bad++; $display("FAIL lanes_count got=%0d want=3", obs_wb.size()); end
        for (int i = 0; i < 3 && i < obs_wb.size(); i++) begin
            total++;
            if (obs_wb[i].cyc != k[i] + 2 || obs_wb[i].err !== 1'b0) begin
                bad++; $display("FAIL lanes_ack%0d got=cyc%0d err%b want=cyc%0d err0", i, obs_wb[i].cyc, obs_wb[i].err, k[i] + 2);
            end
        end
        total++;
        if (obs_wb.size() < 3 || obs_wb[2].dat !== 64'hDEADBEAA) begin
            bad++; $display("FAIL lanes_data got=%h want=deadbeaa", obs_wb.size() < 3 ? 64'h0 : obs_wb[2].dat);
        end
    endtask

    task automatic test_misaligned();
        int k;
        obs_wb.delete();
        k = cyc_n;
        wb_req(1'b1, 12'h012, 32'h00000055, 4'hF); step();
        wb_req(1'b0, 12'h010, 32'h0, 4'hF); step();
        wb_req(1'b0, 12'h013, 32'h0, 4'hF); step();
        wb_idle(1'b1); repeat (4) step();
        total++;
        if (obs_wb.size() != 3) begin bad++; $display("FAIL misal_count got=%0d want=3", obs_wb.size()); end
        else begin
            total++;
            if (obs_wb[0].cyc != k + 2 || obs_wb[0].err !== 1'b1) begin
                bad++; $display("FAIL misal_wr_err got=cyc%0d err%b want=cyc%0d err1", obs_wb[0].cyc, obs_wb[0].err, k + 2);
            end
            total++;
            if (obs_wb[1].err !== 1'b0 || obs_wb[1].dat !== 64'hDEADBEAA) begin
                bad++; $display("FAIL misal_unchanged got=err%b %h want=err0 deadbeaa", obs_wb[1].err, obs_wb[1].dat);
            end
            total++;
            if (obs_wb[2].err !== 1'b1 || obs_wb[2].dat !== 64'h0) begin
                bad++; $display("FAIL misal_rd_err got=err%b %h want=err1 0", obs_wb[2].err, obs_wb[2].dat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        for (int i = 0; i < 3; i++) begin wb_req(1'b1, 12'(i * 4), 32'(i + 1), 4'hF); step(); end
        wb_idle(1'b1); repeat (3) step();
        obs_inst.delete();
        k = cyc_n;
        for (int i = 0; i < 3; i++) begin bus.i_stb_inst = 1'b1; bus.i_inst_addr = 12'(i * 4); step(); end
        bus.i_stb_inst = 1'b0; repeat (4) step();
        total++;
        if (obs_inst.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", obs_inst.size()); end
        for (int i = 0; i < 3 && i < obs_inst.size(); i++) begin
            total++;
            if (obs_inst[i].cyc != k + 2 + i || obs_inst[i].dat !== 64'(i + 1)) begin
                bad++; $display("FAIL b2b_%0d got=cyc%0d %h want=cyc%0d %0d", i, obs_inst[i].cyc, obs_inst[i].dat, k + 2 + i, i + 1);
            end
        end
    endtask

    task automatic test_cyc_drop();
        int k;
        obs_wb.delete(); obs_inst.delete();
        k = cyc_n;
        wb_req(1'b0, 12'h020, 32'h0, 4'hF); step();
        wb_req(1'b0, 12'h024, 32'h0, 4'hF); bus.i_stb_inst = 1'b1; bus.i_inst_addr = 12'h008; step();
        wb_idle(1'b0); bus.i_stb_inst = 1'b0; step();
        wb_idle(1'b1); repeat (6) step();
        total++;
        if (obs_wb.size() != 0) begin bad++; $display("FAIL drop_wb got=%0d rsp want=0", obs_wb.size()); end
        total++;
        if (obs_inst.size() != 1 || obs_inst[0].cyc != k + 3 || obs_inst[0].dat !== 64'h3) begin
            bad++; $display("FAIL drop_inst got=%0d rsp want=1 at cyc%0d of 3", obs_inst.size(), k + 3);
        end
    endtask

    task automatic test_random();
        rsp_t e;
        int k;
        logic [11:0] ia, wa;
        bit wst, we, cyc;
        obs_wb.delete(); obs_inst.delete(); exp_wb.delete(); exp_inst.delete();
        both_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            k = cyc_n;
            ia = 12'($urandom_range(0, 255));
            bus.i_inst_addr = ia;
            bus.i_stb_inst = 1'($urandom_range(0, 1));
            if (bus.i_stb_inst) begin
                e.cyc = k + 2; e.err = 1'b0; e.wr = 1'b0; e.dat = 64'(mrd(ia));
                exp_inst.push_back(e);
            end
            cyc = ($urandom_range(0, 19) != 0);
            wst = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            wa  = 12'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 7) == 0) wa[1:0] = 2'($urandom_range(1, 3));
            if (!cyc) begin
                while (exp_wb.size() > 0 && exp_wb[exp_wb.size() - 1].cyc >= k) exp_wb.delete(exp_wb.size() - 1);
                wb_idle(1'b0);
            end else if (wst) begin
                e.cyc = k + 2; e.err = (wa[1:0] != 2'b00); e.wr = we;
                e.dat = e.err ? 64'h0 : 64'(mrd(wa));
                exp_wb.push_back(e);
                wb_req(we, wa, $urandom, 4'($urandom));
            end else begin
                wb_idle(1'b1);
            end
            step();
        end
        bus.i_stb_inst = 1'b0; wb_idle(1'b1); repeat (4) step();
        total++;
        if (obs_wb.size() != exp_wb.size()) begin
            bad++; $display("FAIL rand_wb_count got=%0d want=%0d", obs_wb.size(), exp_wb.size());
        end
        for (int i = 0; i < exp_wb.size() && i < obs_wb.size(); i++) begin
            total++;
            if (obs_wb[i].cyc != exp_wb[i].cyc || obs_wb[i].err !== exp_wb[i].err ||
                (!exp_wb[i].wr && obs_wb[i].dat !== exp_wb[i].dat)) begin
                bad++; $display("FAIL rand_wb%0d got=cyc%0d err%b %h want=cyc%0d err%b %h", i, obs_wb[i].cyc,
                    obs_wb[i].err, obs_wb[i].dat, exp_wb[i].cyc, exp_wb[i].err, exp_wb[i].dat);
            end
        end
        total++;
        if (obs_inst.size() != exp_inst.size()) begin
            bad++; $display("FAIL rand_inst_count got=%0d want=%0d", obs_inst.size(), exp_inst.size());
        end
        for (int i = 0; i < exp_inst.size() && i < obs_inst.size(); i++) begin
            total++;
            if (obs_inst[i].cyc != exp_inst[i].cyc || obs_inst[i].dat !== exp_inst[i].dat) begin
                bad++; $display("FAIL rand_inst%0d got=cyc%0d %h want=cyc%0d %h", i, obs_inst[i].cyc,
                    obs_inst[i].dat, exp_inst[i].cyc, exp_inst[i].dat);
            end
        end
        total++;
        if (both_cnt != 0) begin bad++; $display("FAIL ack_err_overlap got=%0d want=0", both_cnt); end
    endtask

    task automatic test_reset_midflight();
        int n, k;
        bus.i_stb_inst = 1'b1; bus.i_inst_addr = 12'h004; wb_req(1'b0, 12'h010, 32'h0, 4'hF); step();
        bus.i_inst_addr = 12'h008; wb_req(1'b0, 12'h014, 32'h0, 4'hF); step();
        bus.i_stb_inst = 1'b0; wb_idle(1'b1);
        total++;
        if (bus.o_ack_inst !== 1'b1 || bus.o_wb_ack !== 1'b1) begin
            bad++; $display("FAIL midrst_pre got=%b%b want=11", bus.o_ack_inst, bus.o_wb_ack);
        end
        obs_wb.delete(); obs_inst.delete();
        #1 i_rst = 1'b1;
        #1;
        total++;
        if ({bus.o_ack_inst, bus.o_wb_ack, bus.o_wb_err, bus.o_ready} !== 4'b0000) begin
            bad++; $display("FAIL midrst_flags got=%b want=0000", {bus.o_ack_inst, bus.o_wb_ack, bus.o_wb_err, bus.o_ready});
        end
        total++;
        if (bus.o_inst_out !== 32'h0 || bus.o_wb_data !== 32'h0) begin
            bad++; $display("FAIL midrst_data got=%h %h want=0 0", bus.o_inst_out, bus.o_wb_data);
        end
        wb_idle(1'b0);
        repeat (3) step();
        i_rst = 1'b0;
        wait_ready(n);
        total++;
        if (n != EXP_READY) begin bad++; $display("FAIL midrst_ready got=%0d want=%0d", n, EXP_READY); end
        total++;
        if (obs_wb.size() != 0 || obs_inst.size() != 0) begin
            bad++; $display("FAIL midrst_flush got=%0d,%0d rsp want=0,0", obs_wb.size(), obs_inst.size());
        end
`ifdef MAIN_MEMORY_CLEAR_EN
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
`endif
        k = cyc_n;
        wb_req(1'b0, 12'h010, 32'h0, 4'hF); step();
        wb_idle(1'b1); repeat (4) step();
        total++;
        if (obs_wb.size() != 1 || obs_wb[0].cyc != k + 2 || obs_wb[0].dat !== 64'(mrd(12'h010))) begin
            bad++; $display("FAIL midrst_mem got=%0d rsp want=1 of %h", obs_wb.size(), mrd(12'h010));
        end
    endtask

    task automatic test_wide();
        int n, k;
        n = 0;
        while (wbus.o_ready !== 1'b1 && n < 3000) begin step(); n++; end
        total++;
        if (wbus.o_ready !== 1'b1) begin bad++; $display("FAIL wide_ready got=0 want=1"); end
        obs_w.delete();
        wbus.i_wb_cyc = 1'b1; wbus.i_wb_stb = 1'b1; wbus.i_wb_we = 1'b1; wbus.i_wb_addr = 12'h008;
        wbus.i_wb_data = 64'h0; wbus.i_wb_sel = 8'hFF; step();
        wbus.i_wb_data = 64'h0123456789ABCDEF; wbus.i_wb_sel = 8'hF0; step();
        wbus.i_wb_we = 1'b0; k = cyc_n; step();
        wbus.i_wb_stb = 1'b0; repeat (7) step();
        total++;
        if (obs_w.size() != 3) begin bad++; $display("FAIL wide_count got=%0d want=3", obs_w.size()); end
        else begin
            total++;
            if (obs_w[2].cyc != k + 4 || obs_w[2].err !== 1'b0 || obs_w[2].dat !== 64'h01234567_00000000) begin
                bad++; $display("FAIL wide_read got=cyc%0d err%b %h want=cyc%0d err0 0123456700000000",
                    obs_w[2].cyc, obs_w[2].err, obs_w[2].dat, k + 4);
            end
        end
    endtask

    initial begin
        bus.i_stb_inst = 1'b0; bus.i_inst_addr = '0;
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
        wbus.i_stb_inst = 1'b0; wbus.i_inst_addr = '0;
        wbus.i_wb_cyc = 1'b0; wbus.i_wb_stb = 1'b0; wbus.i_wb_we = 1'b0;
        wbus.i_wb_addr = '0; wbus.i_wb_data = '0; wbus.i_wb_sel = '0;
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        #1 i_rst = 1'b1;
        test_reset();
        test_ready();
        test_preload();
        test_byte_lanes();
        test_misaligned();
        test_back_to_back();
        test_cyc_drop();
        test_random();
        test_reset_midflight();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/main_memory_pipelined.md
MAIN_MEMORY_PIPELINED -- requirements
Module: main_memory_pipelined

Interface
REQ-001 Parameter MEMORY_DEPTH, default 4096: memory size in bytes; power of two, at least 64.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits; legal values 32 or 64.
REQ-003 Parameter READ_LATENCY, default 2: cycles from request acceptance to ack; legal range 1..4.
REQ-004 Derived widths SHALL be AW = $clog2(MEMORY_DEPTH), SW = DATA_WIDTH/8 and OB = $clog2(SW).
REQ-005 i_clk  in  1  single clock; all state changes on the rising edge.
REQ-006 i_rst  in  1  reset, asynchronous and active-high.
REQ-007 i_inst_addr  in  AW  instruction byte address; low OB bits ignored.
REQ-008 i_stb_inst  in  1  instruction request strobe.
REQ-009 o_inst_stall  out  1  instruction request not accepted this cycle.
REQ-010 o_ack_inst  out  1  o_inst_out valid this cycle.
REQ-011 o_inst_out  out  DATA_WIDTH  instruction word.
REQ-012 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined cycle, strobe and write enable.
REQ-013 i_wb_addr  in  AW  data byte address.
REQ-014 i_wb_data  in  DATA_WIDTH  write data.
REQ-015 i_wb_sel  in  SW  byte lane enables; bit k selects byte lane [8k+7:8k].
REQ-016 o_wb_stall, o_wb_ack, o_wb_err  out  1 each  Wishbone stall, ack and error.
REQ-017 o_wb_data  out  DATA_WIDTH  read data.
REQ-018 o_ready  out  1  high once the memory accepts requests.

Function
REQ-019 The block SHALL use a two-state FSM: CLEAR and READY.
- o_ready = (state == READY).
- o_inst_stall = o_wb_stall = !o_ready.
REQ-020 Request acceptance:
- Instruction request is accepted when i_stb_inst && !o_inst_stall.
- Data request is accepted when i_wb_cyc && i_wb_stb && !o_wb_stall.
- Each port accepts at most one request per cycle; the two ports are fully independent.
REQ-021 Each port SHALL carry a READ_LATENCY-deep valid/kind shift pipeline.
- Every accepted request produces exactly one response exactly READ_LATENCY cycles after acceptance.
- Responses are returned in order.
REQ-022 Read data SHALL be sampled at acceptance. A write accepted in an earlier cycle is visible to the read. A write accepted in the same cycle on the data port is not visible.
REQ-023 A data write SHALL update memory at the acceptance edge, writing only the lanes with i_wb_sel set. A write with i_wb_sel == 0 changes no memory and still acks.
REQ-024 Data misalignment:
- A data request with i_wb_addr[OB-1:0] != 0 SHALL NOT write memory.
- It returns o_wb_err instead of o_wb_ack at the same latency.
- o_wb_data for that response is zero.
REQ-025 o_wb_ack and o_wb_err SHALL never be high together and are single-cycle pulses per response.
REQ-026 If i_wb_cyc is low in any cycle, all in-flight data responses are discarded and no later ack or err is issued for them. Writes already performed remain in memory.
REQ-027 A dropped i_wb_cyc SHALL NOT affect the instruction pipeline.
REQ-028 Simultaneous instruction read and data write to the same word SHALL return the old word on the instruction port.
REQ-029 Response payloads:
- o_inst_out and o_wb_data hold their last value when no response is due.
- For reads, o_wb_data is zero while o_wb_err is high.
- For writes, o_wb_data is don't-care while o_wb_ack is high.

Reset
REQ-030 While i_rst is high, and immediately on its assertion, the following SHALL hold:
- Pipelines are cleared.
- o_ack_inst, o_wb_ack and o_wb_err are 0.
- o_inst_out and o_wb_data are 0.
- The FSM is in CLEAR, or in READY per REQ-032.
REQ-031 Reset asserted mid-transaction SHALL discard all in-flight responses. Memory contents are unaffected unless the clear sequence of REQ-032 runs.

Configuration
REQ-032 With macro MAIN_MEMORY_CLEAR_EN defined:
- After reset release, the FSM stays in CLEAR.
- It writes zero to one word per cycle, index 0 to MEMORY_DEPTH/SW-1, using a word counter.
- It enters READY the cycle after the last word is written, so o_ready rises MEMORY_DEPTH/SW cycles after reset release.
REQ-033 Without MAIN_MEMORY_CLEAR_EN:
- The FSM enters READY at the first clock edge after reset release.
- No clear counter exists.
- Memory contents are undefined until written.

Verification
REQ-034 Defaults, CLEAR_EN defined; release reset -> o_ready low for 1024 cycles, then high. A data read of any address after o_ready rises returns 0x00000000.
REQ-035 Write 0xDEADBEEF to 0x010 with sel=0xF, then next cycle write 0x000000AA to 0x010 with sel=0x1, then read 0x010 -> ack 2 cycles after each acceptance; read returns 0xDEADBEAA.
REQ-036 Back-to-back instruction reads of 0x000, 0x004, 0x008 on consecutive cycles (preloaded 1,2,3) -> o_ack_inst high on 3 consecutive cycles starting 2 cycles after the first request, with data 1, 2, 3.
REQ-037 Write to 0x012 with data 0x55 and sel=0xF -> o_wb_err pulse at latency 2 with no ack; a following read of 0x010 is unchanged.
REQ-038 Issue 2 reads, then drop i_wb_cyc one cycle later -> no ack or err is ever observed for either read.
REQ-039 DATA_WIDTH=64, READ_LATENCY=4: write 0x0123456789ABCDEF to 0x008 with sel=0xF0, then read 0x008 -> ack 4 cycles after acceptance; data 0x01234567_00000000 (lower lanes cleared).
